core_mem_stage: RTL and testbench
=================================

# core_mem_stage

Memory-access (MEM) stage of the RV32IMF pipeline, between the execute stage and the writeback stage. Issues loads and stores to the data memory over a req/gnt/rvalid handshake and stalls the upstream pipeline while an access is outstanding. Delivers a registered MEM/WB bundle (rd value, byte-aligned raw load data, load funct3, load select) that the writeback stage consumes for sign/zero extension and the register-file write.

## Interface
- `DATA_WIDTH`, `` `DATA_WIDTH `` (32), datapath width; the block supports only 32.
- `clk_i` in 1: clock, rising edge.
- `rstn_i` in 1: asynchronous active-low reset.
- `m_valid_i` in 1: execute-stage instruction valid.
- `m_is_load_i`, `m_is_store_i` in 1: memory-op class; never both 1.
- `m_alu_result_i` in 32: effective address for load/store; rd value otherwise.
- `m_store_data_i` in 32: rs2 value for stores.
- `m_funct3_i` in 3: load/store width code (`` `LOAD_LB ``=000, LH=001, LW=010, LBU=100, LHU=101; SB=000, SH=001, SW=010).
- `m_rd_addr_i` in 5, `m_regfile_we_i` in 1: destination register and write enable.
- `mem_stall_o` out 1: upstream must hold all `m_*` inputs stable while 1.
- `mem_exc_o` out 1: misaligned/unsupported access, one-cycle pulse.
- `data_req_o` out 1, `data_gnt_i` in 1: request/grant.
- `data_addr_o` out 32, `data_we_o` out 1, `data_be_o` out 4, `data_wdata_o` out 32: request fields.
- `data_rvalid_i` in 1, `data_rdata_i` in 32: read response.
- `w_valid_o`, `w_regfile_we_o`, `w_is_load_store_o` out 1: writeback controls; `w_is_load_store_o`=1 only for loads.
- `w_regfile_rd_o` out 32, `w_data_rdata_o` out 32, `w_LOAD_op_o` out 3, `w_rd_addr_o` out 5: writeback data.

## Operation
- `op` = `m_valid_i & (m_is_load_i | m_is_store_i)`. `off` = `m_alu_result_i[1:0]`.
- Misaligned when: funct3 001/101 with `off[0]`=1; funct3 010 with `off`!=0; store funct3 not in {000,001,010}; load funct3 in {011,110,111}. A misaligned op issues no request, pulses `mem_exc_o`, and retires as a bubble (`w_valid_o`=0).
- `data_addr_o` = `{m_alu_result_i[31:2],2'b00}`. `data_we_o` = `m_is_store_i`.
- `data_be_o`: SB `4'b0001<<off`, SH `4'b0011<<off`, SW `4'b1111`, loads `4'b1111`.
- `data_wdata_o`: SB `{4{rs2[7:0]}}`, SH `{2{rs2[15:0]}}`, SW rs2.
- FSM states IDLE, WAIT_GNT, WAIT_RVALID.
  - IDLE: aligned `op` -> `data_req_o`=1 combinationally. With gnt: store completes; load -> WAIT_RVALID. Without gnt -> WAIT_GNT.
  - WAIT_GNT: `data_req_o`=1, fields stable. On gnt: store completes -> IDLE; load -> WAIT_RVALID.
  - WAIT_RVALID: `data_req_o`=0. On `data_rvalid_i`: load completes -> IDLE.
- `mem_stall_o` = aligned `op` and not completing this cycle.
- `w_data_rdata_o` = `data_rdata_i >> (8*off)`, captured at load completion.
- MEM/WB register, updated every cycle:
  - Non-memory valid instruction, or memory op completing: load all `w_*`. `w_regfile_we_o` = `m_regfile_we_i & ~m_is_store_i`. `w_LOAD_op_o` = funct3.
  - Otherwise (stall, misaligned, or `m_valid_i`=0): bubble, `w_valid_o`=0, `w_regfile_we_o`=0.
- `data_rvalid_i` is ignored outside WAIT_RVALID, including when it coincides with gnt in WAIT_GNT.

## Timing
- Reset: state IDLE; all `w_*` outputs and `mem_exc_o` = 0. `data_*` request outputs = 0 while `rstn_i`=0.
- Reset mid-access abandons the transaction. A late rvalid arriving afterwards is ignored.
- Non-memory latency: 1 cycle to `w_*`. Store: 1 cycle with gnt in the issue cycle. Load: minimum 2 cycles (gnt at N, rvalid at N+1, `w_*` valid at N+2). Each gnt wait cycle and each rvalid wait cycle adds 1.
- `mem_exc_o` is registered: it is high in the cycle after the misaligned op is presented.
- At most one outstanding access.

## Test plan
- ADD result 0x0000_1234, rd=5, we=1 -> next cycle `w_valid_o`=1, `w_regfile_rd_o`=0x1234, `w_rd_addr_o`=5, `w_is_load_store_o`=0, no `data_req_o`.
- SB rs2=0xAABB_CCDD to addr 0x103, gnt immediate -> `data_addr_o`=0x100, `data_be_o`=1000, `data_wdata_o`=0xDDDD_DDDD, `mem_stall_o`=0, `w_regfile_we_o`=0.
- LH addr 0x202, gnt after 2 wait cycles, rdata=0x8001_0000 one cycle later -> `mem_stall_o` high for 3 cycles, `w_data_rdata_o`=0x0000_8001, `w_LOAD_op_o`=001.
- LW addr 0x301 -> no request, `mem_exc_o` pulse, `w_valid_o`=0; a spurious `data_rvalid_i` in IDLE causes no writeback.
- Load granted, then `rstn_i` pulsed low before rvalid -> state IDLE, all `w_*`=0, a later rvalid is ignored.
- Back-to-back LBU 0x401 (rdata 0x0000_7F00) then SW -> `w_data_rdata_o`=0x0000_007F, the store issues in the cycle after load completion.

Source files
------------

// File: rtl/core_mem_stage.sv
// MEM stage: issues aligned loads/stores over req/gnt/rvalid, stalls upstream while busy,
// and registers the MEM/WB bundle consumed by writeback.
module core_mem_stage #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                    clk_i,
  input  logic                    rstn_i,
  input  logic                    m_valid_i,
  input  logic                    m_is_load_i,
  input  logic                    m_is_store_i,
  input  logic [DATA_WIDTH-1:0]   m_alu_result_i,
  input  logic [DATA_WIDTH-1:0]   m_store_data_i,
  input  logic [2:0]              m_funct3_i,
  input  logic [4:0]              m_rd_addr_i,
  input  logic                    m_regfile_we_i,
  output logic                    mem_stall_o,
  output logic                    mem_exc_o,
  output logic                    data_req_o,
  input  logic                    data_gnt_i,
  output logic [DATA_WIDTH-1:0]   data_addr_o,
  output logic                    data_we_o,
  output logic [3:0]              data_be_o,
  output logic [DATA_WIDTH-1:0]   data_wdata_o,
  input  logic                    data_rvalid_i,
  input  logic [DATA_WIDTH-1:0]   data_rdata_i,
  output logic                    w_valid_o,
  output logic                    w_regfile_we_o,
  output logic                    w_is_load_store_o,
  output logic [DATA_WIDTH-1:0]   w_regfile_rd_o,
  output logic [DATA_WIDTH-1:0]   w_data_rdata_o,
  output logic [2:0]              w_LOAD_op_o,
  output logic [4:0]              w_rd_addr_o
);

  typedef enum logic [1:0] {StIdle, StWaitGnt, StWaitRvalid} state_e;

  state_e r_state;

  logic [1:0]            w_off;
  logic                  w_op;
  logic                  w_misaligned;
  logic                  w_aligned_op;
  logic                  w_complete;
  logic                  w_wb_load;
  logic [3:0]            w_be;
  logic [DATA_WIDTH-1:0] w_wdata;

  assign w_off        = m_alu_result_i[1:0];
  assign w_op         = m_valid_i & (m_is_load_i | m_is_store_i);
  assign w_aligned_op = w_op & ~w_misaligned;

  always_comb begin
    w_misaligned = 1'b0;
    if (m_is_store_i) begin
      case (m_funct3_i)
        3'b000:  w_misaligned = 1'b0;
        3'b001:  w_misaligned = w_off[0];
        3'b010:  w_misaligned = |w_off;
        default: w_misaligned = 1'b1;
      endcase
    end else begin
      case (m_funct3_i)
        3'b000, 3'b100: w_misaligned = 1'b0;
        3'b001, 3'b101: w_misaligned = w_off[0];
        3'b010:         w_misaligned = |w_off;
        default:        w_misaligned = 1'b1;
      endcase
    end
  end

  always_comb begin
    w_be    = 4'b1111;
    w_wdata = m_store_data_i;
    if (m_is_store_i) begin
      case (m_funct3_i[1:0])
        2'b00: begin
          w_be    = 4'b0001 << w_off;
          w_wdata = {4{m_store_data_i[7:0]}};
        end
        2'b01: begin
          w_be    = 4'b0011 << w_off;
          w_wdata = {2{m_store_data_i[15:0]}};
        end
        default: begin
          w_be    = 4'b1111;
          w_wdata = m_store_data_i;
        end
      endcase
    end
  end

  // Stores finish on grant; loads only on rvalid, and rvalid counts only in StWaitRvalid.
  always_comb begin
    w_complete = 1'b0;
    unique case (r_state)
      StIdle, StWaitGnt: w_complete = w_aligned_op & data_gnt_i & m_is_store_i;
      StWaitRvalid:      w_complete = w_aligned_op & data_rvalid_i;
      default:           w_complete = 1'b0;
    endcase
  end

  assign w_wb_load   = (m_valid_i & ~(m_is_load_i | m_is_store_i)) | w_complete;
  assign mem_stall_o = w_aligned_op & ~w_complete;

  // Request fields forced to zero while reset is asserted.
  assign data_req_o   = rstn_i & w_aligned_op & (r_state != StWaitRvalid);
  assign data_addr_o  = rstn_i ? {m_alu_result_i[DATA_WIDTH-1:2], 2'b00} : '0;
  assign data_we_o    = rstn_i & m_is_store_i;
  assign data_be_o    = rstn_i ? w_be : 4'b0000;
  assign data_wdata_o = rstn_i ? w_wdata : '0;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_state <= StIdle;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (w_aligned_op) begin
            if (!data_gnt_i)       r_state <= StWaitGnt;
            else if (m_is_load_i)  r_state <= StWaitRvalid;
          end
        end
        StWaitGnt: begin
          if (data_gnt_i) r_state <= m_is_load_i ? StWaitRvalid : StIdle;
        end
        StWaitRvalid: begin
          if (data_rvalid_i) r_state <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      mem_exc_o         <= 1'b0;
      w_valid_o         <= 1'b0;
      w_regfile_we_o    <= 1'b0;
      w_is_load_store_o <= 1'b0;
      w_regfile_rd_o    <= '0;
      w_data_rdata_o    <= '0;
      w_LOAD_op_o       <= 3'b000;
      w_rd_addr_o       <= 5'd0;
    end else begin
      mem_exc_o <= w_op & w_misaligned;
      if (w_wb_load) begin
        w_valid_o         <= 1'b1;
        w_regfile_we_o    <= m_regfile_we_i & ~m_is_store_i;
        w_is_load_store_o <= m_is_load_i;
        w_regfile_rd_o    <= m_alu_result_i;
        w_data_rdata_o    <= data_rdata_i >> {w_off, 3'b000};
        w_LOAD_op_o       <= m_funct3_i;
        w_rd_addr_o       <= m_rd_addr_i;
      end else begin
        w_valid_o      <= 1'b0;
        w_regfile_we_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_core_mem_stage.sv
// Randomized self-checking bench for core_mem_stage with a bench-driven memory responder
// and an access-size based reference model.
module tb_core_mem_stage;

  logic        clk_i = 1'b0;
  logic        rstn_i;
  logic        m_valid_i, m_is_load_i, m_is_store_i;
  logic [31:0] m_alu_result_i, m_store_data_i;
  logic [2:0]  m_funct3_i;
  logic [4:0]  m_rd_addr_i;
  logic        m_regfile_we_i;
  logic        mem_stall_o, mem_exc_o;
  logic        data_req_o, data_gnt_i;
  logic [31:0] data_addr_o;
  logic        data_we_o;
  logic [3:0]  data_be_o;
  logic [31:0] data_wdata_o;
  logic        data_rvalid_i;
  logic [31:0] data_rdata_i;
  logic        w_valid_o, w_regfile_we_o, w_is_load_store_o;
  logic [31:0] w_regfile_rd_o, w_data_rdata_o;
  logic [2:0]  w_LOAD_op_o;
  logic [4:0]  w_rd_addr_o;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk_i = ~clk_i;

  core_mem_stage #(.DATA_WIDTH(32)) u_dut (
    .clk_i             (clk_i),
    .rstn_i            (rstn_i),
    .m_valid_i         (m_valid_i),
    .m_is_load_i       (m_is_load_i),
    .m_is_store_i      (m_is_store_i),
    .m_alu_result_i    (m_alu_result_i),
    .m_store_data_i    (m_store_data_i),
    .m_funct3_i        (m_funct3_i),
    .m_rd_addr_i       (m_rd_addr_i),
    .m_regfile_we_i    (m_regfile_we_i),
    .mem_stall_o       (mem_stall_o),
    .mem_exc_o         (mem_exc_o),
    .data_req_o        (data_req_o),
    .data_gnt_i        (data_gnt_i),
    .data_addr_o       (data_addr_o),
    .data_we_o         (data_we_o),
    .data_be_o         (data_be_o),
    .data_wdata_o      (data_wdata_o),
    .data_rvalid_i     (data_rvalid_i),
    .data_rdata_i      (data_rdata_i),
    .w_valid_o         (w_valid_o),
    .w_regfile_we_o    (w_regfile_we_o),
    .w_is_load_store_o (w_is_load_store_o),
    .w_regfile_rd_o    (w_regfile_rd_o),
    .w_data_rdata_o    (w_data_rdata_o),
    .w_LOAD_op_o       (w_LOAD_op_o),
    .w_rd_addr_o       (w_rd_addr_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Access size in bytes; 0 marks an unsupported funct3.
  function automatic int unsigned acc_size(input logic ld, input logic [2:0] f3);
    if (ld) begin
      case (f3)
        3'd0, 3'd4: return 1;
        3'd1, 3'd5: return 2;
        3'd2:       return 4;
        default:    return 0;
      endcase
    end
    case (f3)
      3'd0:    return 1;
      3'd1:    return 2;
      3'd2:    return 4;
      default: return 0;
    endcase
  endfunction

  task automatic chk_bubble(input string tag);
    chk({tag, "_wvalid"}, w_valid_o, 0);
    chk({tag, "_wwe"}, w_regfile_we_o, 0);
    chk({tag, "_exc"}, mem_exc_o, 0);
  endtask

  // Entered and left at posedge+1; g gnt wait cycles, r rvalid wait cycles.
  task automatic run_op(input logic v, input logic ld, input logic st, input logic [31:0] addr,
                        input logic [31:0] sdata, input logic [2:0] f3, input logic [4:0] rd,
                        input logic we, input int g, input int r, input logic [31:0] rdata);
    int unsigned size, off;
    bit          mem, mis;
    logic [3:0]  exp_be;
    logic [31:0] exp_wd;
    m_valid_i = v; m_is_load_i = ld; m_is_store_i = st; m_alu_result_i = addr;
    m_store_data_i = sdata; m_funct3_i = f3; m_rd_addr_i = rd; m_regfile_we_i = we;
    data_gnt_i = 1'b0; data_rvalid_i = 1'b0;
    mem  = v && (ld || st);
    size = acc_size(ld, f3);
    off  = addr % 4;
    mis  = mem && (size == 0 || (addr % size) != 0);
    exp_be = 4'hF;
    exp_wd = sdata;
    if (st && size == 1) begin
      exp_be = 4'(1 << off);
      exp_wd = {24'd0, sdata[7:0]} * 32'h0101_0101;
    end else if (st && size == 2) begin
      exp_be = 4'(3 << off);
      exp_wd = {16'd0, sdata[15:0]} * 32'h0001_0001;
    end
    if (!mem || mis) begin
      #4;
      chk("noreq", data_req_o, 0);
      chk("nostall", mem_stall_o, 0);
      @(posedge clk_i) #1;
      chk("exc", mem_exc_o, mis);
      if (mem || !v) begin
        chk("bub_wvalid", w_valid_o, 0);
        chk("bub_wwe", w_regfile_we_o, 0);
      end else begin
        chk("alu_wvalid", w_valid_o, 1);
        chk("alu_wwe", w_regfile_we_o, we);
        chk("alu_wls", w_is_load_store_o, 0);
        chk("alu_wrd", w_regfile_rd_o, addr);
        chk("alu_wrdaddr", w_rd_addr_o, rd);
      end
      return;
    end
    for (int c = 0; c <= g; c++) begin
      data_gnt_i    = (c == g);
      data_rvalid_i = 1'($urandom_range(0, 1));
      data_rdata_i  = $urandom;
      #4;
      chk("req", data_req_o, 1);
      chk("addr", data_addr_o, addr & 32'hFFFF_FFFC);
      chk("we", data_we_o, st);
      chk("be", data_be_o, exp_be);
      if (st) chk("wdata", data_wdata_o, exp_wd);
      chk("stall_req", mem_stall_o, ld || (c < g));
      @(posedge clk_i) #1;
      if (ld || c < g) chk_bubble("req_wait");
    end
    data_gnt_i    = 1'b0;
    data_rvalid_i = 1'b0;
    if (ld) begin
      for (int c = 0; c <= r; c++) begin
        data_rvalid_i = (c == r);
        data_rdata_i  = (c == r) ? rdata : $urandom;
        #4;
        chk("req_rv", data_req_o, 0);
        chk("stall_rv", mem_stall_o, c < r);
        @(posedge clk_i) #1;
        if (c < r) chk_bubble("rv_wait");
      end
      data_rvalid_i = 1'b0;
    end
    chk("mem_wvalid", w_valid_o, 1);
    chk("mem_wwe", w_regfile_we_o, we && !st);
    chk("mem_wls", w_is_load_store_o, ld);
    chk("mem_wrd", w_regfile_rd_o, addr);
    chk("mem_wrdaddr", w_rd_addr_o, rd);
    chk("mem_exc", mem_exc_o, 0);
    if (ld) begin
      chk("ld_rdata", w_data_rdata_o, rdata >> (8 * off));
      chk("ld_op", w_LOAD_op_o, f3);
    end
  endtask

  logic [2:0] lf3 [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
  logic [2:0] sf3 [3] = '{3'd0, 3'd1, 3'd2};

  initial begin
    rstn_i = 1'b0;
    m_valid_i = 1'b1; m_is_load_i = 1'b0; m_is_store_i = 1'b1;
    m_alu_result_i = 32'hDEAD_BEEF; m_store_data_i = 32'h1234_5678; m_funct3_i = 3'd2;
    m_rd_addr_i = 5'd3; m_regfile_we_i = 1'b1;
    data_gnt_i = 1'b1; data_rvalid_i = 1'b0; data_rdata_i = '0;
    #3;
    chk("rst_req", data_req_o, 0);
    chk("rst_addr", data_addr_o, 0);
    chk("rst_be", data_be_o, 0);
    chk("rst_wvalid", w_valid_o, 0);
    chk("rst_exc", mem_exc_o, 0);
    chk("rst_wrd", w_regfile_rd_o, 0);
    m_valid_i = 1'b0; data_gnt_i = 1'b0;
    @(posedge clk_i) #1;
    rstn_i = 1'b1;

    run_op(1, 0, 0, 32'h0000_1234, 0, 3'd0, 5'd5, 1, 0, 0, 0);
    run_op(1, 0, 1, 32'h0000_0103, 32'hAABB_CCDD, 3'd0, 5'd3, 1, 0, 0, 0);
    run_op(1, 1, 0, 32'h0000_0202, 0, 3'd1, 5'd7, 1, 2, 0, 32'h8001_0000);
    run_op(1, 1, 0, 32'h0000_0301, 0, 3'd2, 5'd8, 1, 0, 0, 0);
    m_valid_i = 1'b0; data_rvalid_i = 1'b1; data_rdata_i = 32'hFFFF_FFFF;
    #4;
    chk("spur_req", data_req_o, 0);
    @(posedge clk_i) #1;
    chk_bubble("spur_rv");
    data_rvalid_i = 1'b0;

    // Reset while a granted load awaits rvalid.
    run_op(1, 0, 0, 32'h0BAD_F00D, 0, 3'd0, 5'd9, 1, 0, 0, 0);
    m_valid_i = 1'b1; m_is_load_i = 1'b1; m_is_store_i = 1'b0;
    m_alu_result_i = 32'h0000_0500; m_funct3_i = 3'd2; data_gnt_i = 1'b1;
    @(posedge clk_i) #1;
    data_gnt_i = 1'b0;
    #2 rstn_i = 1'b0;
    #1;
    chk("mrst_req", data_req_o, 0);
    chk("mrst_we", data_we_o, 0);
    chk("mrst_wdata", data_wdata_o, 0);
    chk("mrst_wvalid", w_valid_o, 0);
    chk("mrst_wrd", w_regfile_rd_o, 0);
    chk("mrst_wrdaddr", w_rd_addr_o, 0);
    chk("mrst_wls", w_is_load_store_o, 0);
    chk("mrst_wrdata", w_data_rdata_o, 0);
    chk("mrst_wop", w_LOAD_op_o, 0);
    m_valid_i = 1'b0;
    @(posedge clk_i) #1;
    rstn_i = 1'b1;
    data_rvalid_i = 1'b1; data_rdata_i = 32'h5555_AAAA;
    #4;
    chk("late_req", data_req_o, 0);
    @(posedge clk_i) #1;
    chk_bubble("late_rv");
    chk("late_wrd", w_regfile_rd_o, 0);
    data_rvalid_i = 1'b0;
    run_op(1, 0, 1, 32'h0000_0704, 32'h0102_0304, 3'd2, 5'd1, 0, 0, 0, 0);

    run_op(1, 1, 0, 32'h0000_0401, 0, 3'd4, 5'd10, 1, 0, 0, 32'h0000_7F00);
    run_op(1, 0, 1, 32'h0000_0600, 32'h1234_5678, 3'd2, 5'd0, 0, 0, 0, 0);

    for (int i = 0; i < 300; i++) begin
      logic        v, ld, st, we;
      logic [31:0] addr;
      logic [2:0]  f3;
      int          cls;
      v    = ($urandom_range(0, 9) != 0);
      cls  = $urandom_range(0, 2);
      ld   = (cls == 1);
      st   = (cls == 2);
      we   = 1'($urandom_range(0, 1));
      addr = $urandom;
      if ($urandom_range(0, 1) == 1) addr[1:0] = 2'b00;
      if ($urandom_range(0, 4) == 0) f3 = 3'($urandom_range(0, 7));
      else if (st) f3 = sf3[$urandom_range(0, 2)];
      else f3 = lf3[$urandom_range(0, 4)];
      run_op(v, ld, st, addr, $urandom, f3, 5'($urandom_range(0, 31)), we,
             $urandom_range(0, 3), $urandom_range(0, 3), $urandom);
    end
    run_op(0, 0, 0, 0, 0, 3'd0, 5'd0, 0, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
